fpmul_sched: RTL and testbench

FPMUL_SCHED -- requirements
Module: fpmul_sched

---
 rtl/fpmul_sched.sv | 144 ++++++++++++++
 tb/tb_fpmul_sched.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpmul_sched.sv
// Round-robin scheduler sharing one pipelined FP multiplier among N_REQ requesters.
// Define FPMUL_SCHED_PRIO0_EN to give requester 0 fixed top priority.
module fpmul_sched #(
  parameter int N_REQ   = 4,
  parameter int MUL_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_en,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [32*N_REQ-1:0]  req_a,
  input  logic [32*N_REQ-1:0]  req_b,
  output logic [N_REQ-1:0]     req_ready,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic [31:0]          mul_p,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [31:0]          rsp_data,
  output logic                 busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  typedef logic [PW-1:0] idx_t;

  idx_t               rr_ptr_q, rr_ptr_d;
  logic [31:0]        mul_a_q, mul_a_d;
  logic [31:0]        mul_b_q, mul_b_d;
  logic               iss_vld_q, iss_vld_d;
  idx_t               iss_idx_q, iss_idx_d;
  logic [MUL_LAT-1:0] tag_vld_q, tag_vld_d;
  idx_t               tag_idx_q [MUL_LAT];
  idx_t               tag_idx_d [MUL_LAT];
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_data_q, rsp_data_d;

  logic               gnt_vld;
  idx_t               gnt_idx;
  idx_t               cand;

  // Search from rr_ptr upward; lowest offset wins, so scan high to low.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = idx_t'((int'(rr_ptr_q) + k) % N_REQ);
      if (req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
`ifdef FPMUL_SCHED_PRIO0_EN
    if (req_valid[0]) begin
      gnt_vld = 1'b1;
      gnt_idx = '0;
    end
`else
`endif
    if (reset || !clk_en) begin
      gnt_vld = 1'b0;
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_vld) begin
      req_ready = N_REQ'(1) << gnt_idx;
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    iss_vld_d   = iss_vld_q;
    iss_idx_d   = iss_idx_q;
    tag_vld_d   = tag_vld_q;
    tag_idx_d   = tag_idx_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    if (clk_en) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt_vld && gnt_idx == idx_t'(i)) begin
          mul_a_d = req_a[32*i +: 32];
          mul_b_d = req_b[32*i +: 32];
        end
      end
      if (gnt_vld) begin
        rr_ptr_d = idx_t'((int'(gnt_idx) + 1) % N_REQ);
`ifdef FPMUL_SCHED_PRIO0_EN
        if (gnt_idx == '0) begin
          rr_ptr_d = rr_ptr_q;
        end
`else
`endif
      end
      iss_vld_d    = gnt_vld;
      iss_idx_d    = gnt_idx;
      // Tag stages track the multiplier's internal pipeline one-for-one.
      tag_vld_d[0] = iss_vld_q;
      tag_idx_d[0] = iss_idx_q;
      for (int k = 1; k < MUL_LAT; k++) begin
        tag_vld_d[k] = tag_vld_q[k-1];
        tag_idx_d[k] = tag_idx_q[k-1];
      end
      rsp_valid_d = '0;
      if (tag_vld_q[MUL_LAT-1]) begin
        rsp_valid_d = N_REQ'(1) << tag_idx_q[MUL_LAT-1];
        rsp_data_d  = mul_p;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      iss_vld_q   <= 1'b0;
      iss_idx_q   <= '0;
      tag_vld_q   <= '0;
      tag_idx_q   <= '{default: '0};
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      iss_vld_q   <= iss_vld_d;
      iss_idx_q   <= iss_idx_d;
      tag_vld_q   <= tag_vld_d;
      tag_idx_q   <= tag_idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = iss_vld_q | (|tag_vld_q);

endmodule

// File: tb/tb_fpmul_sched.sv
// Bench for fpmul_sched: queue-based model, bench-side multiplier, directed vectors.
// Honours FPMUL_SCHED_PRIO0_EN when the design is built with it.
module tb_fpmul_sched;

  localparam int N = 4;
  localparam int L = 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           clk_en;
  logic [N-1:0]   req_valid;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic [31:0]    mul_a;
  logic [31:0]    mul_b;
  logic [31:0]    mul_p;
  logic [N-1:0]   rsp_valid;
  logic [31:0]    rsp_data;
  logic           busy;

  fpmul_sched #(.N_REQ(N), .MUL_LAT(L)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b),
    .mul_p(mul_p), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

`ifdef FPMUL_SCHED_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  int vecs = 0;
  int errs = 0;
  bit chk  = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Single-precision helpers for normal, exactly representable values.
  function automatic real s2r(input logic [31:0] a);
    int e;
    logic [63:0] bits;
    if (a[30:23] == 8'd0) return 0.0;
    e = int'(a[30:23]) - 127 + 1023;
    bits = {a[31], e[10:0], a[22:0], 29'd0};
    return $bitstoreal(bits);
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] bits;
    int e;
    if (r == 0.0) return 32'd0;
    bits = $realtobits(r);
    e = int'(bits[62:52]) - 1023 + 127;
    return {bits[63], e[7:0], bits[51:29]};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    return r2s(s2r(a) * s2r(b));
  endfunction

  // Shared multiplier, pipelined L deep, stalls with clk_en.
  logic [31:0] pipe [L];
  initial for (int k = 0; k < L; k++) pipe[k] = 32'd0;
  always @(posedge clk) begin
    if (clk_en) begin
      pipe[0] <= fmul(mul_a, mul_b);
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end
  end
  assign mul_p = pipe[L-1];

  // Model state: pointer, in-flight queue with due enabled-edge counts.
  int          m_rr  = 0;
  int          m_cnt = 0;
  int          q_idx [$];
  logic [31:0] q_p   [$];
  int          q_due [$];
  logic [N-1:0] m_rv = '0;
  logic [31:0] m_rd = 32'd0;
  logic [31:0] m_ma = 32'd0;
  logic [31:0] m_mb = 32'd0;

  function automatic int m_grant();
    if (reset || !clk_en) return -1;
    if (PRIO0 && req_valid[0]) return 0;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int g;
    logic [N-1:0] eg;
    g  = m_grant();
    eg = (g < 0) ? '0 : (N'(1) << g);
    if (chk) begin
      check("req_ready", 32'(req_ready), 32'(eg));
      check("rsp_valid", 32'(rsp_valid), 32'(m_rv));
      check("rsp_data", rsp_data, m_rd);
      check("mul_a", mul_a, m_ma);
      check("mul_b", mul_b, m_mb);
      check("busy", 32'(busy), 32'(q_idx.size() != 0));
    end
    if (reset) begin
      m_rr = 0;
      q_idx.delete();
      q_p.delete();
      q_due.delete();
      m_rv = '0;
      m_rd = 32'd0;
      m_ma = 32'd0;
      m_mb = 32'd0;
    end else if (clk_en) begin
      m_cnt++;
      m_rv = '0;
      if (q_due.size() > 0 && q_due[0] == m_cnt) begin
        m_rv = N'(1) << q_idx[0];
        m_rd = q_p[0];
        void'(q_idx.pop_front());
        void'(q_p.pop_front());
        void'(q_due.pop_front());
      end
      if (g >= 0) begin
        m_ma = req_a[32*g +: 32];
        m_mb = req_b[32*g +: 32];
        q_idx.push_back(g);
        q_p.push_back(fmul(m_ma, m_mb));
        q_due.push_back(m_cnt + L + 1);
        if (!(PRIO0 && g == 0)) m_rr = (g + 1) % N;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic wait_rsp(input string name, input int idx, input int exp_n,
                          input logic [31:0] exp_d);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      got = rsp_valid[idx];
    end
    check({name, "_lat"}, 32'(n), 32'(exp_n));
    check({name, "_data"}, rsp_data, exp_d);
  endtask

  logic [31:0] tbl [6];

  initial begin
    tbl[0] = 32'h3F800000; tbl[1] = 32'h40000000; tbl[2] = 32'h3FC00000;
    tbl[3] = 32'h40400000; tbl[4] = 32'hC0000000; tbl[5] = 32'h3F000000;
    reset = 1'b1;
    clk_en = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    cyc(2);
    chk = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp", 32'(rsp_valid), 32'd0);
    reset = 1'b0;

    // 1.0 * 2.0 from requester 0
    set_req(0, 32'h3F800000, 32'h40000000);
    req_valid = 4'b0001;
    cyc(1);
    req_valid = '0;
    wait_rsp("t_one_two", 0, 2, 32'h40000000);
    cyc(2);

    // All four requesters from reset
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    set_req(0, 32'h3F800000, 32'h40000000);
    set_req(1, 32'h40000000, 32'h40000000);
    set_req(2, 32'h40400000, 32'h40000000);
    set_req(3, 32'h40800000, 32'h40000000);
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rr_order", 32'(req_ready), PRIO0 ? 32'd1 : 32'(1 << (k % 4)));
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    cyc(L + 2);

    // 1.5 * 1.5 with a 3-cycle enable stall mid-flight
    set_req(2, 32'h3FC00000, 32'h3FC00000);
    req_valid = 4'b0100;
    cyc(1);
    req_valid = '0;
    clk_en = 1'b0;
    cyc(3);
    clk_en = 1'b1;
    wait_rsp("t_stall", 2, 2, 32'h40100000);
    cyc(2);

    // Reset with two products in flight
    set_req(1, 32'h40000000, 32'h3F000000);
    set_req(3, 32'h40400000, 32'h40400000);
    req_valid = 4'b1010;
    cyc(2);
    req_valid = '0;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("flush_rsp", 32'(rsp_valid), 32'd0);
      check("flush_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
    end
    req_valid = 4'hF;
    @(negedge clk);
    check("flush_next_gnt", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = '0;
    cyc(L + 2);

    // 3.0 * -2.0 from requester 3, pointer wraps to 0
    set_req(3, 32'h40400000, 32'hC0000000);
    req_valid = 4'b1000;
    cyc(1);
    req_valid = '0;
    wait_rsp("t_neg", 3, 2, 32'hC0C00000);
    req_valid = 4'hF;
    @(negedge clk);
    check("wrap_gnt", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = '0;
    cyc(L + 2);

    // Requesters 0 and 1 held: alternate, or 0 only with priority
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    req_valid = 4'b0011;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("pair_gnt", 32'(req_ready),
            PRIO0 ? 32'd1 : ((k % 2) != 0 ? 32'd2 : 32'd1));
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    cyc(L + 2);

    // Mixed traffic, withdrawals and enable gaps
    for (int k = 0; k < 80; k++) begin
      req_valid = N'($urandom);
      clk_en = ($urandom % 5) != 0;
      for (int i = 0; i < N; i++) begin
        set_req(i, tbl[$urandom % 6], tbl[$urandom % 6]);
      end
      cyc(1);
    end
    clk_en = 1'b1;
    req_valid = '0;
    cyc(L + 4);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
